jb_lphy_frm_mrkr_gen: RTL and testbench

Generates per-carrier DL, UL and PRACH frame-marker pulses for the LPHY from the common control block's frame-marker settings (enable, trigger, per-carrier ns offsets, stream enables). It runs a free-running 10 ms frame-time counter in ns, re-aligned by the timers' frame sync. It fires a one-cycle marker when frame time crosses each programmed offset. Sits directly downstream of the common control registers and upstream of the DL/UL/PRACH LPHY datapaths.

---
 rtl/jb_lphy_frm_mrkr_gen_if.sv | 35 +++
 rtl/jb_lphy_frm_mrkr_gen.sv | 145 ++++++++++++++
 tb/tb_jb_lphy_frm_mrkr_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/jb_lphy_frm_mrkr_gen_if.sv
// Frame-marker generator bus: control-block settings in, LPHY markers and frame status out.
interface jb_lphy_frm_mrkr_gen_if;
    logic                  frame_sync;
    logic [1:0]            frm_mrkr_gen_enable;
    logic [1:0]            frm_mrkr_gen_trigger;
    logic [1:0][3:0]       dl_stream_en;
    logic [1:0][3:0]       ul_stream_en;
    logic [1:0][31:0]      dl_frm_mrkr_cntr_ns;
    logic [1:0][31:0]      ul_frm_mrkr_cntr_ns;
    logic [1:0][31:0]      prach_frm_mrkr_cntr_ns;
    logic [1:0]            dl_frm_mrkr;
    logic [1:0]            ul_frm_mrkr;
    logic [1:0]            prach_frm_mrkr;
    logic [23:0]           frm_ns;
    logic                  frame_start;
    logic [9:0]            sfn;
    logic [1:0]            car_running;
    logic [1:0]            cfg_err;

    modport master (
        output frame_sync, frm_mrkr_gen_enable, frm_mrkr_gen_trigger,
               dl_stream_en, ul_stream_en,
               dl_frm_mrkr_cntr_ns, ul_frm_mrkr_cntr_ns, prach_frm_mrkr_cntr_ns,
        input  dl_frm_mrkr, ul_frm_mrkr, prach_frm_mrkr,
               frm_ns, frame_start, sfn, car_running, cfg_err
    );

    modport slave (
        input  frame_sync, frm_mrkr_gen_enable, frm_mrkr_gen_trigger,
               dl_stream_en, ul_stream_en,
               dl_frm_mrkr_cntr_ns, ul_frm_mrkr_cntr_ns, prach_frm_mrkr_cntr_ns,
        output dl_frm_mrkr, ul_frm_mrkr, prach_frm_mrkr,
               frm_ns, frame_start, sfn, car_running, cfg_err
    );
endinterface

// File: rtl/jb_lphy_frm_mrkr_gen.sv
// Per-carrier DL/UL/PRACH frame-marker pulse generator driven by a free-running
// ns frame counter that frame_sync can re-align at any point.
module jb_lphy_frm_mrkr_gen #(
    parameter int NS_INC   = 4,
    parameter int FRAME_NS = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    jb_lphy_frm_mrkr_gen_if.slave  bus
);
    localparam logic [23:0] INC_NS  = 24'(NS_INC);
    localparam logic [23:0] LAST_NS = 24'(FRAME_NS - NS_INC);
    localparam logic [31:0] FRM_LEN = 32'(FRAME_NS);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

    logic [23:0]       frm_ns_q, frm_ns_d, prev_ns_q;
    logic              frame_start_q, frame_start_d;
    logic [9:0]        sfn_q, sfn_d;
    logic [1:0]        trig_q, rise;
    state_t [1:0]      state_q, state_d;
    logic [1:0]        shadow_ld;
    logic [1:0][31:0]  dl_sh_q, ul_sh_q, pr_sh_q;
    logic [1:0][31:0]  dl_sh_d, ul_sh_d, pr_sh_d;
    logic [1:0]        dl_mrkr_q, ul_mrkr_q, pr_mrkr_q;
    logic [1:0]        dl_mrkr_d, ul_mrkr_d, pr_mrkr_d;
    logic [1:0]        cfg_err_q, cfg_err_d;

    // A frame_start cycle compares against live offsets: it also catches offsets
    // skipped by the wrap window or cut short by an early frame_sync.
    function automatic logic hit(input logic [31:0] off, input logic [23:0] cur,
                                 input logic [23:0] prev, input logic fs,
                                 input state_t st);
        logic [31:0] c32;
        logic [31:0] p32;
        logic        fire;
        c32  = {8'd0, cur};
        p32  = {8'd0, prev};
        fire = 1'b0;
        if (off < FRM_LEN) begin
            if (st == ST_RUN)
                fire = fs ? ((off == 32'd0) || (off > p32)) : ((p32 < off) && (off <= c32));
            else if (st == ST_ARMED)
                fire = fs && (off == 32'd0);
        end
        return fire;
    endfunction

    always_comb begin
        frame_start_d = (frm_ns_q == LAST_NS) || bus.frame_sync;
        frm_ns_d      = frame_start_d ? 24'd0 : frm_ns_q + INC_NS;
        sfn_d         = frame_start_d ? sfn_q + 10'd1 : sfn_q;
    end

    assign rise = bus.frm_mrkr_gen_trigger & ~trig_q;

    always_comb begin
        state_d   = state_q;
        shadow_ld = '0;
        dl_sh_d   = dl_sh_q;
        ul_sh_d   = ul_sh_q;
        pr_sh_d   = pr_sh_q;
        dl_mrkr_d = '0;
        ul_mrkr_d = '0;
        pr_mrkr_d = '0;
        cfg_err_d = cfg_err_q;
        for (int c = 0; c < 2; c++) begin
            if (!bus.frm_mrkr_gen_enable[c]) begin
                state_d[c] = ST_IDLE;
            end else begin
                case (state_q[c])
                    ST_IDLE:  if (rise[c]) state_d[c] = ST_ARMED;
                    ST_ARMED: if (frame_start_q) state_d[c] = ST_RUN;
                    ST_RUN:   state_d[c] = ST_RUN;
                    default:  state_d[c] = ST_IDLE;
                endcase
            end

            shadow_ld[c] = frame_start_q && (state_q[c] != ST_IDLE);
            if (shadow_ld[c]) begin
                dl_sh_d[c] = bus.dl_frm_mrkr_cntr_ns[c];
                ul_sh_d[c] = bus.ul_frm_mrkr_cntr_ns[c];
                pr_sh_d[c] = bus.prach_frm_mrkr_cntr_ns[c];
            end

            dl_mrkr_d[c] = (|bus.dl_stream_en[c]) &&
                hit(frame_start_q ? bus.dl_frm_mrkr_cntr_ns[c] : dl_sh_q[c],
                    frm_ns_q, prev_ns_q, frame_start_q, state_q[c]);
            ul_mrkr_d[c] = (|bus.ul_stream_en[c]) &&
                hit(frame_start_q ? bus.ul_frm_mrkr_cntr_ns[c] : ul_sh_q[c],
                    frm_ns_q, prev_ns_q, frame_start_q, state_q[c]);
            pr_mrkr_d[c] = (|bus.ul_stream_en[c]) &&
                hit(frame_start_q ? bus.prach_frm_mrkr_cntr_ns[c] : pr_sh_q[c],
                    frm_ns_q, prev_ns_q, frame_start_q, state_q[c]);

            if (!bus.frm_mrkr_gen_enable[c])
                cfg_err_d[c] = 1'b0;
            else if (shadow_ld[c] && ((bus.dl_frm_mrkr_cntr_ns[c] >= FRM_LEN) ||
                                      (bus.ul_frm_mrkr_cntr_ns[c] >= FRM_LEN) ||
                                      (bus.prach_frm_mrkr_cntr_ns[c] >= FRM_LEN)))
                cfg_err_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_ns_q      <= '0;
            prev_ns_q     <= '0;
            frame_start_q <= 1'b0;
            sfn_q         <= '0;
            trig_q        <= '0;
            state_q       <= {ST_IDLE, ST_IDLE};
            dl_sh_q       <= '0;
            ul_sh_q       <= '0;
            pr_sh_q       <= '0;
            dl_mrkr_q     <= '0;
            ul_mrkr_q     <= '0;
            pr_mrkr_q     <= '0;
            cfg_err_q     <= '0;
        end else begin
            frm_ns_q      <= frm_ns_d;
            prev_ns_q     <= frm_ns_q;
            frame_start_q <= frame_start_d;
            sfn_q         <= sfn_d;
            trig_q        <= bus.frm_mrkr_gen_trigger;
            state_q       <= state_d;
            dl_sh_q       <= dl_sh_d;
            ul_sh_q       <= ul_sh_d;
            pr_sh_q       <= pr_sh_d;
            dl_mrkr_q     <= dl_mrkr_d;
            ul_mrkr_q     <= ul_mrkr_d;
            pr_mrkr_q     <= pr_mrkr_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign bus.frm_ns         = frm_ns_q;
    assign bus.frame_start    = frame_start_q;
    assign bus.sfn            = sfn_q;
    assign bus.dl_frm_mrkr    = dl_mrkr_q;
    assign bus.ul_frm_mrkr    = ul_mrkr_q;
    assign bus.prach_frm_mrkr = pr_mrkr_q;
    assign bus.cfg_err        = cfg_err_q;
    assign bus.car_running    = {state_q[1] == ST_RUN, state_q[0] == ST_RUN};
endmodule

// File: tb/tb_jb_lphy_frm_mrkr_gen.sv
// Directed bench for jb_lphy_frm_mrkr_gen with a 1000 ns frame and 4 ns step (250 cycles per frame).
module tb_jb_lphy_frm_mrkr_gen;
    localparam int NS_INC   = 4;
    localparam int FRAME_NS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jb_lphy_frm_mrkr_gen_if bus();

    jb_lphy_frm_mrkr_gen #(.NS_INC(NS_INC), .FRAME_NS(FRAME_NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // exp_* is the frm_ns value seen in the pulse cycle; -1 means no pulse in the frame.
    typedef struct {
        int         car;
        int         dl_off;
        int         ul_off;
        int         pr_off;
        logic [3:0] dl_en;
        logic [3:0] ul_en;
        int         exp_dl;
        int         exp_ul;
        int         exp_pr;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_off(input int c, input int dl, input int ul, input int pr);
        bus.dl_frm_mrkr_cntr_ns[c]    = 32'(dl);
        bus.ul_frm_mrkr_cntr_ns[c]    = 32'(ul);
        bus.prach_frm_mrkr_cntr_ns[c] = 32'(pr);
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        do begin tick(); n++; end while (!bus.frame_start && n < 400);
        chk(name, int'(bus.frame_start), 1);
    endtask

    task automatic wait_ns(input string name, input int v);
        int n;
        n = 0;
        do begin tick(); n++; end while (int'(bus.frm_ns) != v && n < 400);
        chk(name, int'(bus.frm_ns), v);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_frm_ns"}, int'(bus.frm_ns), 0);
        chk({pfx, "_frame_start"}, int'(bus.frame_start), 0);
        chk({pfx, "_sfn"}, int'(bus.sfn), 0);
        chk({pfx, "_markers"}, int'({bus.dl_frm_mrkr, bus.ul_frm_mrkr, bus.prach_frm_mrkr}), 0);
        chk({pfx, "_car_running"}, int'(bus.car_running), 0);
        chk({pfx, "_cfg_err"}, int'(bus.cfg_err), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, s;
        int c, cd, cu, cp, pd, pu, pp;

        vecs[0] = '{1,    0,  998,  500, 4'hF, 4'hF,   4,   4, 504, 0};
        vecs[1] = '{0,  100,  600,    0, 4'hF, 4'hF, 104, 604,   4, 0};
        vecs[2] = '{0,  998,  996,  102, 4'hF, 4'hF,   4,   0, 108, 0};
        vecs[3] = '{0,  500,  500,  500, 4'h0, 4'hF,  -1, 504, 504, 0};
        vecs[4] = '{1,    4,  200,  999, 4'hF, 4'h0,   8,  -1,  -1, 0};
        vecs[5] = '{0, 1000,    3, 1200, 4'hF, 4'hF,  -1,   8,  -1, 1};

        bus.frame_sync           = 1'b0;
        bus.frm_mrkr_gen_enable  = 2'b00;
        bus.frm_mrkr_gen_trigger = 2'b00;
        bus.dl_stream_en         = {4'hF, 4'hF};
        bus.ul_stream_en         = {4'hF, 4'hF};
        set_off(0, 100, 300, 300);
        set_off(1, 0, 0, 0);

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (20) tick();

        // Arm both carriers mid-frame; carrier 0 must stay silent until the first frame_start
        bus.frm_mrkr_gen_enable  = 2'b11;
        bus.frm_mrkr_gen_trigger = 2'b11;
        tick();
        bus.frm_mrkr_gen_trigger = 2'b00;
        cnt = 0;
        n = 0;
        do begin tick(); n++; cnt += int'(bus.dl_frm_mrkr[0]); end
        while (!bus.frame_start && n < 400);
        chk("arm_first_fs", int'(bus.frame_start), 1);
        chk("arm_no_early_dl", cnt, 0);
        chk("armed_not_running", int'(bus.car_running), 0);
        chk("armed_sfn", int'(bus.sfn), 1);
        tick();
        chk("run_after_fs", int'(bus.car_running), 3);
        chk("armed_off0_car1", int'(bus.dl_frm_mrkr[1]), 1);
        n = 0;
        while (!bus.dl_frm_mrkr[0] && n < 300) begin tick(); n++; end
        chk("dl100_pos", int'(bus.frm_ns), 104);
        n = 0;
        do begin tick(); n++; end while (!bus.dl_frm_mrkr[0] && n < 300);
        chk("dl100_period", n, 250);
        tick();
        chk("dl100_one_cycle", int'(bus.dl_frm_mrkr[0]), 0);

        // Mid-frame offset change only takes effect from the next frame
        wait_ns("reach_300", 300);
        set_off(0, 500, 300, 300);
        cnt = 0;
        n = 0;
        do begin tick(); n++; cnt += int'(bus.dl_frm_mrkr[0]); end
        while (!bus.frame_start && n < 400);
        chk("midchg_no_dl", cnt, 0);
        n = 0;
        while (!bus.dl_frm_mrkr[0] && n < 300) begin tick(); n++; end
        chk("midchg_next_pos", int'(bus.frm_ns), 504);

        // Early frame_sync at 400
        set_off(0, 700, 600, 200);
        wait_fs("sync_prep_fs");
        wait_ns("reach_400", 400);
        s = int'(bus.sfn);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        chk("sync_frm_ns", int'(bus.frm_ns), 0);
        chk("sync_fs", int'(bus.frame_start), 1);
        chk("sync_sfn", int'(bus.sfn), (s + 1) % 1024);
        tick();
        chk("sync_ul600_fires", int'(bus.ul_frm_mrkr[0]), 1);
        chk("sync_pr200_quiet", int'(bus.prach_frm_mrkr[0]), 0);

        // frame_sync coinciding with the natural wrap counts once
        wait_ns("reach_996", 996);
        s = int'(bus.sfn);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        chk("wrapsync_frm_ns", int'(bus.frm_ns), 0);
        chk("wrapsync_sfn", int'(bus.sfn), (s + 1) % 1024);
        tick();
        chk("wrapsync_fs_low", int'(bus.frame_start), 0);
        chk("wrapsync_step", int'(bus.frm_ns), 4);
        chk("wrapsync_sfn_once", int'(bus.sfn), (s + 1) % 1024);

        // Table of per-frame offset/stream-enable vectors
        for (int r = 0; r < 6; r++) begin
            c = vecs[r].car;
            set_off(c, vecs[r].dl_off, vecs[r].ul_off, vecs[r].pr_off);
            bus.dl_stream_en[c] = vecs[r].dl_en;
            bus.ul_stream_en[c] = vecs[r].ul_en;
            wait_fs($sformatf("row%0d_fs", r));
            cd = 0; cu = 0; cp = 0; pd = 0; pu = 0; pp = 0;
            for (int k = 0; k < 250; k++) begin
                tick();
                if (bus.dl_frm_mrkr[c])    begin cd++; pd = int'(bus.frm_ns); end
                if (bus.ul_frm_mrkr[c])    begin cu++; pu = int'(bus.frm_ns); end
                if (bus.prach_frm_mrkr[c]) begin cp++; pp = int'(bus.frm_ns); end
            end
            chk($sformatf("row%0d_dl", r), (cd == 0) ? -1 : ((cd > 1) ? -2 : pd), vecs[r].exp_dl);
            chk($sformatf("row%0d_ul", r), (cu == 0) ? -1 : ((cu > 1) ? -2 : pu), vecs[r].exp_ul);
            chk($sformatf("row%0d_pr", r), (cp == 0) ? -1 : ((cp > 1) ? -2 : pp), vecs[r].exp_pr);
            chk($sformatf("row%0d_cfg_err", r), int'(bus.cfg_err[c]), vecs[r].exp_err);
        end

        // Dropping enable clears cfg_err and RUN, and silences the carrier
        bus.frm_mrkr_gen_enable = 2'b10;
        tick();
        chk("drop_cfg_err", int'(bus.cfg_err[0]), 0);
        chk("drop_running", int'(bus.car_running), 2);
        tick();
        cnt = 0;
        for (int k = 0; k < 260; k++) begin
            tick();
            cnt += int'(bus.dl_frm_mrkr[0]) + int'(bus.ul_frm_mrkr[0]) + int'(bus.prach_frm_mrkr[0]);
        end
        chk("drop_no_markers", cnt, 0);

        // Reset mid-frame; carrier stays quiet until re-triggered
        bus.dl_stream_en[1] = 4'hF;
        bus.ul_stream_en[1] = 4'hF;
        set_off(1, 100, 200, 300);
        wait_ns("reach_500", 500);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            cnt += int'(bus.dl_frm_mrkr[1]) + int'(bus.ul_frm_mrkr[1]) + int'(bus.prach_frm_mrkr[1]);
        end
        chk("postrst_no_markers", cnt, 0);
        chk("postrst_not_running", int'(bus.car_running), 0);
        bus.frm_mrkr_gen_trigger = 2'b10;
        tick();
        bus.frm_mrkr_gen_trigger = 2'b00;
        wait_fs("retrig_fs");
        tick();
        chk("retrig_running", int'(bus.car_running), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
